multicycle_control: RTL

Multicycle sequencing controller for the MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives one shared memory port, the ALU and the register file per state. It replaces the single-cycle opcode decoder and adds a memory ready handshake. Opcode and ALUOp encodings are unchanged from the single-cycle core, so the ALU control block is reused as is.

---
 rtl/mips_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_output_decode.sv | 87 ++++++++
 rtl/multicycle_control.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALUOp codes,
// state numbering, mux select codes and the internal control-word struct.
package mips_ctrl_pkg;

    localparam logic [5:0] R_Type = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0c;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] LUI    = 6'h0f;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2b;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_NOR   = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_HALT      = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       link;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       zero_imm;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
        logic [2:0] res;
        case (op)
            ORI:     res = ALU_OR;
            ANDI:    res = ALU_AND;
            LUI:     res = ALU_LUI;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    // Logical immediates are zero-extended, arithmetic ones sign-extended.
    function automatic logic itype_zero_imm(input logic [5:0] op);
        return (op == ORI) || (op == ANDI);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from controller state (plus OP, Zero, MemReady) to the
// full datapath control word. Fields a state does not name stay 0.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state control word
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = itype_alu_op(op);
                ctrl.zero_imm  = itype_zero_imm(op);
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = itype_alu_op(op);
                ctrl.zero_imm  = itype_zero_imm(op);
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = ((op == BEQ) && zero) || ((op == BNE) && !zero);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.reg_write = 1'b1;
                ctrl.link      = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: state register, next-state logic and
// reset gating. Define ILLEGAL_TRAP_EN to trap unknown opcodes in HALT.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               Link,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               ZeroImm,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [STATE_W-1:0] State
);

    state_e state_q, state_d;
    ctrl_t  dec_s, ctrl_s;

    mc_output_decode u_output_decode (
        .state     (state_q),
        .op        (OP),
        .zero      (Zero),
        .mem_ready (MemReady),
        .ctrl      (dec_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until MemReady
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    LW, SW:                state_d = S_MEM_ADDR;
                    R_Type:                state_d = S_R_EXEC;
                    ADDI, ORI, ANDI, LUI:  state_d = S_I_EXEC;
                    BEQ, BNE:              state_d = S_BRANCH;
                    J:                     state_d = S_JUMP;
                    JAL:                   state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:               state_d = S_HALT;
`else
                    default:               state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_d = (OP == LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = MemReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL:
                         state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    // Everything reads 0 while reset is held low
    always_comb begin
        if (reset) begin
            ctrl_s = dec_s;
        end else begin
            ctrl_s = '0;
        end
    end

    assign PCWrite  = ctrl_s.pc_write;
    assign IorD     = ctrl_s.iord;
    assign MemRead  = ctrl_s.mem_read;
    assign MemWrite = ctrl_s.mem_write;
    assign IRWrite  = ctrl_s.ir_write;
    assign MemtoReg = ctrl_s.mem_to_reg;
    assign RegDst   = ctrl_s.reg_dst;
    assign RegWrite = ctrl_s.reg_write;
    assign Link     = ctrl_s.link;
    assign ALUSrcA  = ctrl_s.alu_src_a;
    assign ALUSrcB  = ctrl_s.alu_src_b;
    assign PCSource = ctrl_s.pc_source;
    assign ZeroImm  = ctrl_s.zero_imm;
    assign ALUOp    = ALUOP_W'(ctrl_s.alu_op);
    assign State    = reset ? STATE_W'(state_q) : '0;

endmodule
